// File: rtl/zbt_port_arbiter.sv
// ZBT SRAM single-port scheduler: read-priority grant, buffered writes,
// starvation-forced write slot, and the ZBT read/write data pipelines.
module zbt_port_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic [18:0] rd_addr,
   output logic        rd_ack,
   output logic        rd_valid,
   output logic [35:0] rd_data,
   input  logic        wr_req,
   input  logic [18:0] wr_addr,
   input  logic [35:0] wr_data,
   output logic        wr_full,
   output logic        wr_overflow,
   output logic [18:0] mem_addr,
   output logic        mem_we,
   output logic [35:0] mem_write_data,
   input  logic [35:0] mem_read_data
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {ST_NORMAL, ST_FORCE_WR} state_t;
   typedef enum logic [1:0] {G_IDLE, G_READ, G_WRITE} grant_t;

   logic [18:0]   r_faddr [FIFO_DEPTH];
   logic [35:0]   r_fdata [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_ovf;
   state_t        r_state;
   logic [SW-1:0] r_starve;
   logic [18:0]   r_mem_addr;
   logic          r_mem_we;
   logic          r_wv1;
   logic          r_wv2;
   logic [35:0]   r_wd1;
   logic [35:0]   r_wd2;
   logic [35:0]   r_wd_out;
   logic [2:0]    r_rv;
   logic          r_rd_valid;
   logic [35:0]   r_rd_data;

   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   grant_t        w_grant;
   logic [CW-1:0] w_count_nxt;
   logic [SW-1:0] w_starve_inc;

   assign w_empty      = (r_count == '0);
   assign w_push       = wr_req & ~r_full;
   assign w_pop        = (w_grant == G_WRITE);
   assign w_starve_inc = r_starve + SW'(1);

   always_comb begin
      w_grant = G_IDLE;
      if (r_state == ST_FORCE_WR) begin
         if (!w_empty) w_grant = G_WRITE;
      end else if (rd_req) begin
         w_grant = G_READ;
      end else if (!w_empty) begin
         w_grant = G_WRITE;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
      if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
   end

   assign rd_ack = rd_req & ~reset & (w_grant == G_READ);

   // Storage needs no reset: pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_faddr[r_wptr] <= wr_addr;
         r_fdata[r_wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
         r_ovf   <= r_ovf | (wr_req & r_full);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_NORMAL;
         r_starve <= '0;
      end else if (r_state == ST_FORCE_WR) begin
         r_state  <= ST_NORMAL;
         r_starve <= '0;
      end else if (w_pop || w_empty) begin
         r_starve <= '0;
      end else if (w_grant == G_READ) begin
         r_starve <= w_starve_inc;
         if (w_starve_inc == SW'(STARVE_LIMIT)) r_state <= ST_FORCE_WR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_addr <= '0;
         r_mem_we   <= 1'b0;
      end else begin
         case (w_grant)
            G_READ: begin
               r_mem_addr <= rd_addr;
               r_mem_we   <= 1'b0;
            end
            G_WRITE: begin
               r_mem_addr <= r_faddr[r_rptr];
               r_mem_we   <= 1'b1;
            end
            default: r_mem_we <= 1'b0;
         endcase
      end
   end

   // Write data trails its address by two cycles on the ZBT bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wv1    <= 1'b0;
         r_wv2    <= 1'b0;
         r_wd1    <= '0;
         r_wd2    <= '0;
         r_wd_out <= '0;
      end else begin
         r_wv1 <= w_pop;
         r_wv2 <= r_wv1;
         if (w_pop) r_wd1 <= r_fdata[r_rptr];
         if (r_wv1) r_wd2 <= r_wd1;
         if (r_wv2) r_wd_out <= r_wd2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rv       <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rv       <= {r_rv[1:0], (w_grant == G_READ)};
         r_rd_valid <= r_rv[2];
         if (r_rv[2]) r_rd_data <= mem_read_data;
      end
   end

   assign rd_valid       = r_rd_valid;
   assign rd_data        = r_rd_data;
   assign wr_full        = r_full;
   assign wr_overflow    = r_ovf;
   assign mem_addr       = r_mem_addr;
   assign mem_we         = r_mem_we;
   assign mem_write_data = r_wd_out;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Bench for zbt_port_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_zbt_port_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd_req = 1'b0;
   logic [18:0] rd_addr = '0;
   logic        rd_ack;
   logic        rd_valid;
   logic [35:0] rd_data;
   logic        wr_req = 1'b0;
   logic [18:0] wr_addr = '0;
   logic [35:0] wr_data = '0;
   logic        wr_full;
   logic        wr_overflow;
   logic [18:0] mem_addr;
   logic        mem_we;
   logic [35:0] mem_write_data;
   logic [35:0] mem_read_data;

   int n_chk = 0;
   int n_fail = 0;

   zbt_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk),
      .reset(reset),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_ack(rd_ack),
      .rd_valid(rd_valid),
      .rd_data(rd_data),
      .wr_req(wr_req),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_full(wr_full),
      .wr_overflow(wr_overflow),
      .mem_addr(mem_addr),
      .mem_we(mem_we),
      .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [35:0] memf(input logic [18:0] a);
      if (a == 19'h00123) return 36'hABCDE1234;
      return {a[17:0], ~a[17:0]};
   endfunction

   // SRAM stand-in: data for an address appears two cycles later
   logic [18:0] d1 = '0;
   logic [18:0] d2 = '0;
   always @(posedge clk) begin
      d1 <= mem_addr;
      d2 <= d1;
   end
   assign mem_read_data = memf(d2);

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [18:0] a;
      logic [35:0] d;
   } went_t;
   typedef struct {
      int          due;
      logic [35:0] d;
   } ev_t;

   went_t       m_q[$];
   ev_t         m_rd[$];
   ev_t         m_wd[$];
   int          m_cyc = 0;
   int          m_streak = 0;
   bit          m_force = 0;
   bit          m_ok = 0;
   logic        e_we, e_rvalid, e_full, e_ovf;
   logic [18:0] e_addr;
   logic [35:0] e_wdata, e_rdata;

   // 0 idle, 1 read, 2 write
   function automatic int mgrant();
      if (m_force) return (m_q.size() != 0) ? 2 : 0;
      if (rd_req) return 1;
      return (m_q.size() != 0) ? 2 : 0;
   endfunction

   always @(posedge clk) begin : model
      int    g;
      int    n0;
      went_t h;
      ev_t   ev;
      if (reset) begin
         m_q.delete();
         m_rd.delete();
         m_wd.delete();
         m_streak = 0;
         m_force  = 0;
         m_ok     = 1;
         e_we = 0; e_rvalid = 0; e_full = 0; e_ovf = 0;
         e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else begin
         g  = mgrant();
         n0 = m_q.size();
         if (g == 2) begin
            h = m_q.pop_front();
            e_we = 1; e_addr = h.a;
            m_wd.push_back('{m_cyc + 3, h.d});
         end else if (g == 1) begin
            e_we = 0; e_addr = rd_addr;
            m_rd.push_back('{m_cyc + 4, memf(rd_addr)});
         end else begin
            e_we = 0;
         end
         if (wr_req) begin
            if (n0 == DEPTH) e_ovf = 1;
            else m_q.push_back('{wr_addr, wr_data});
         end
         if (m_force) begin
            m_force = 0; m_streak = 0;
         end else if (g == 2 || n0 == 0) begin
            m_streak = 0;
         end else if (g == 1) begin
            m_streak++;
            if (m_streak >= LIMIT) m_force = 1;
         end
         e_rvalid = 0;
         if (m_rd.size() != 0 && m_rd[0].due == m_cyc + 1) begin
            ev = m_rd.pop_front();
            e_rvalid = 1; e_rdata = ev.d;
         end
         if (m_wd.size() != 0 && m_wd[0].due == m_cyc + 1) begin
            ev = m_wd.pop_front();
            e_wdata = ev.d;
         end
         e_full = (m_q.size() == DEPTH);
      end
      m_cyc++;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("rd_ack", 64'(rd_ack),
             64'(!reset && rd_req && mgrant() == 1));
         chk("mem_we", 64'(mem_we), 64'(e_we));
         chk("mem_addr", 64'(mem_addr), 64'(e_addr));
         chk("mem_write_data", 64'(mem_write_data), 64'(e_wdata));
         chk("rd_valid", 64'(rd_valid), 64'(e_rvalid));
         chk("rd_data", 64'(rd_data), 64'(e_rdata));
         chk("wr_full", 64'(wr_full), 64'(e_full));
         chk("wr_overflow", 64'(wr_overflow), 64'(e_ovf));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   logic        s_ack  [12];
   logic        o_full [14];
   logic        o_ovf  [14];
   logic        o_we   [14];
   logic [18:0] o_ad   [14];
   logic [35:0] o_wd   [14];
   int          acks;
   int          vcnt;
   int          zero_at;
   int          zeros;

   initial begin
      // reset state, rd_ack held low during reset
      cyc();
      rd_req = 1; rd_addr = 19'h77;
      neg();
      chk("ack_in_reset", 64'(rd_ack), 64'd0);
      cyc();
      reset = 0; rd_req = 0;
      neg();
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_write_data), 64'd0);
      chk("rst_full", 64'(wr_full), 64'd0);
      chk("rst_ovf", 64'(wr_overflow), 64'd0);
      chk("rst_rvalid", 64'(rd_valid), 64'd0);
      cyc();

      // single read
      rd_req = 1; rd_addr = 19'h00123;
      neg();
      chk("rd1_ack", 64'(rd_ack), 64'd1);
      cyc();
      for (int k = 1; k <= 5; k++) begin
         rd_req = 0;
         neg();
         if (k == 1) begin
            chk("rd1_addr", 64'(mem_addr), 64'h00123);
            chk("rd1_we", 64'(mem_we), 64'd0);
         end
         chk("rd1_valid", 64'(rd_valid), 64'(k == 4));
         if (k == 4) chk("rd1_data", 64'(rd_data), 64'hABCDE1234);
         cyc();
      end

      // single write, no reads
      wr_req = 1; wr_addr = 19'h7FFFF; wr_data = 36'h3F0FC0FFF;
      neg();
      cyc();
      for (int k = 1; k <= 5; k++) begin
         wr_req = 0;
         neg();
         chk("wr1_we", 64'(mem_we), 64'(k == 2));
         if (k == 2) chk("wr1_addr", 64'(mem_addr), 64'h7FFFF);
         if (k == 4) chk("wr1_data", 64'(mem_write_data), 64'h3F0FC0FFF);
         cyc();
      end

      // starvation guard
      acks = 0; vcnt = 0; zero_at = -1; zeros = 0;
      for (int k = 0; k < 12; k++) begin
         rd_req = 1; rd_addr = 19'h200 + 19'(k);
         wr_req = (k == 0); wr_addr = 19'h55; wr_data = 36'h111;
         neg();
         s_ack[k] = rd_ack;
         acks += int'(rd_ack);
         vcnt += int'(rd_valid);
         if (!rd_ack) begin
            zeros++;
            if (zero_at < 0) zero_at = k;
         end
         if (k == 10) begin
            chk("starve_we", 64'(mem_we), 64'd1);
            chk("starve_addr", 64'(mem_addr), 64'h55);
         end
         cyc();
      end
      rd_req = 0; wr_req = 0;
      for (int k = 0; k < 8; k++) begin
         neg();
         vcnt += int'(rd_valid);
         cyc();
      end
      chk("starve_gap_idx", 64'(zero_at), 64'd9);
      chk("starve_gap_len", 64'(zeros), 64'd1);
      chk("starve_resume", 64'(s_ack[10]), 64'd1);
      chk("starve_acks", 64'(acks), 64'd11);
      chk("starve_valids", 64'(vcnt), 64'd11);

      // overflow, then push+pop at full, then in-order drain
      for (int k = 0; k < 14; k++) begin
         rd_req = (k < 7);
         rd_addr = 19'h300 + 19'(k);
         wr_req = (k < 6) || (k == 7);
         wr_addr = 19'h100 + 19'(k);
         wr_data = 36'hA0000 + 36'(k);
         neg();
         o_full[k] = wr_full; o_ovf[k] = wr_overflow;
         o_we[k] = mem_we; o_ad[k] = mem_addr; o_wd[k] = mem_write_data;
         cyc();
      end
      rd_req = 0; wr_req = 0;
      chk("ovf_full3", 64'(o_full[3]), 64'd0);
      chk("ovf_full4", 64'(o_full[4]), 64'd1);
      chk("ovf_full7", 64'(o_full[7]), 64'd1);
      chk("ovf_full8", 64'(o_full[8]), 64'd0);
      chk("ovf_flag4", 64'(o_ovf[4]), 64'd0);
      chk("ovf_flag5", 64'(o_ovf[5]), 64'd1);
      chk("ovf_sticky", 64'(o_ovf[13]), 64'd1);
      chk("ovf_we7", 64'(o_we[7]), 64'd0);
      chk("ovf_we12", 64'(o_we[12]), 64'd0);
      for (int j = 0; j < 4; j++) begin
         chk("drain_we", 64'(o_we[8+j]), 64'd1);
         chk("drain_addr", 64'(o_ad[8+j]), 64'(19'h100 + 19'(j)));
         chk("drain_data", 64'(o_wd[10+j]), 64'(36'hA0000 + 36'(j)));
      end

      // reset with 2 reads in flight and 3 writes queued
      wr_req = 1; wr_addr = 19'h400; wr_data = 36'h1;
      neg(); cyc();
      rd_req = 1; rd_addr = 19'h500;
      wr_addr = 19'h401; wr_data = 36'h2;
      neg(); cyc();
      rd_addr = 19'h501;
      wr_addr = 19'h402; wr_data = 36'h3;
      neg(); cyc();
      reset = 1; wr_req = 0;
      neg();
      chk("mid_ack_rst", 64'(rd_ack), 64'd0);
      cyc();
      reset = 0; rd_req = 0;
      neg();
      chk("mid_we", 64'(mem_we), 64'd0);
      chk("mid_addr", 64'(mem_addr), 64'd0);
      chk("mid_wdata", 64'(mem_write_data), 64'd0);
      chk("mid_rdata", 64'(rd_data), 64'd0);
      chk("mid_full", 64'(wr_full), 64'd0);
      chk("mid_ovf", 64'(wr_overflow), 64'd0);
      cyc();
      for (int k = 0; k < 6; k++) begin
         neg();
         chk("mid_no_valid", 64'(rd_valid), 64'd0);
         chk("mid_no_we", 64'(mem_we), 64'd0);
         cyc();
      end

      // cold-start write after reset
      wr_req = 1; wr_addr = 19'h0ABCD; wr_data = 36'h123456789;
      neg();
      cyc();
      for (int k = 1; k <= 5; k++) begin
         wr_req = 0;
         neg();
         chk("cold_we", 64'(mem_we), 64'(k == 2));
         if (k == 2) chk("cold_addr", 64'(mem_addr), 64'h0ABCD);
         if (k == 4) chk("cold_data", 64'(mem_write_data), 64'h123456789);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/zbt_port_arbiter.md
# zbt_port_arbiter

Single-port scheduler for one ZBT SRAM bank, shared between the display read stream and the pixel-processing write stream (36-bit words, two 18-bit RGB666 pixels, 19-bit word address). Reads have priority. Writes are buffered in a small FIFO and drained in idle slots. A starvation guard forces a write slot so the processed-pixel stream cannot be locked out. The block sits between the pixel processor / display fetch logic and the ZBT pins, and owns the two-cycle ZBT write-data pipeline.

## Interface
Parameters:
- FIFO_DEPTH, 4: write FIFO entries. Must be a power of two, ≥2.
- STARVE_LIMIT, 8: consecutive read grants allowed while the FIFO is non-empty before a write slot is forced. Must be ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  display read request, one word per cycle.
- rd_addr  in  19  read word address.
- rd_ack  out  1  combinational: rd_req accepted this cycle.
- rd_valid  out  1  rd_data valid; one pulse per accepted read.
- rd_data  out  36  read word.
- wr_req  in  1  processed-word write request.
- wr_addr  in  19  write word address.
- wr_data  in  36  write word.
- wr_full  out  1  FIFO full; wr_req is dropped while high.
- wr_overflow  out  1  sticky; set when a wr_req is dropped.
- mem_addr  out  19  ZBT address, registered.
- mem_we  out  1  ZBT write enable, active high, registered.
- mem_write_data  out  36  ZBT write data, registered, driven 2 cycles after its address.
- mem_read_data  in  36  ZBT read data, valid 2 cycles after its address.

## Operation
- Each cycle exactly one of {READ, WRITE, IDLE} is granted.
- Grant FSM has two states: NORMAL and FORCE_WR.
- NORMAL:
  - rd_req=1 → READ.
  - rd_req=0 and FIFO non-empty → WRITE (pop head).
  - Otherwise IDLE.
- Starvation counter:
  - Increments on each READ grant while the FIFO is non-empty.
  - Clears on any WRITE grant, or on any cycle the FIFO is empty.
  - Reaching STARVE_LIMIT moves the FSM to FORCE_WR.
- FORCE_WR:
  - Grants WRITE for one cycle. rd_ack=0 even if rd_req=1, so the requester holds.
  - Returns to NORMAL and clears the counter.
- rd_ack = rd_req and grant is READ.
- FIFO push:
  - Accepted iff wr_req=1 and wr_full=0, where wr_full is sampled at the start of the cycle.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged.
  - A push to a full FIFO is dropped, even if a pop occurs that cycle, and sets wr_overflow.
- Occupancy is held in a counter of width log2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.
- WRITE grant: mem_addr=head address, mem_we=1. The head data enters a 2-stage delay line and appears on mem_write_data 2 cycles later.
- READ grant: mem_addr=rd_addr, mem_we=0. A 3-stage valid shift register tracks the read in flight.
- IDLE: mem_we=0, mem_addr holds its previous value.
- mem_write_data holds its last value when no write is in the pipeline.

## Timing
- Request in cycle t → mem_addr/mem_we valid in t+1.
- Read: mem_read_data is sampled at the end of t+3 → rd_valid=1 and rd_data in t+4. Fixed latency of 4 cycles; reads return in order.
- Write: FIFO head granted in cycle t → mem_we=1 in t+1 → mem_write_data in t+3.
- Minimum write latency, wr_req to mem_we, is 2 cycles (empty FIFO, no read).
- Back-to-back reads sustain 1 word/cycle, except for the forced write slot: at most STARVE_LIMIT reads per STARVE_LIMIT+1 cycles while writes are pending.
- wr_full is registered and reflects occupancy == FIFO_DEPTH after the previous edge.
- Reset (any cycle, including mid-burst):
  - FIFO emptied; counter=0; FSM=NORMAL.
  - In-flight reads and writes are discarded; pipelines are cleared.
  - Outputs: mem_we=0, mem_addr=0, mem_write_data=0, rd_valid=0, rd_data=0, wr_full=0, wr_overflow=0.
  - rd_ack=0 while reset=1.

## Test plan
- Single read: rd_req=1, rd_addr=19'h00123 at t; model returns 36'hABCDE1234 → mem_addr=19'h00123 with mem_we=0 at t+1; rd_valid=1 and rd_data=36'hABCDE1234 at t+4, and only then.
- Single write, no reads: wr_req with addr 19'h7FFFF, data 36'h3F0FC0FFF → mem_we=1, mem_addr=19'h7FFFF at t+2; mem_write_data=36'h3F0FC0FFF at t+4.
- Starvation: continuous rd_req with 1 write queued, STARVE_LIMIT=8 → 8 READ grants, then rd_ack=0 for exactly one cycle with mem_we=1; reads resume the next cycle; rd_valid count equals rd_ack count.
- Overflow: FIFO_DEPTH=4, continuous rd_req with STARVE_LIMIT large, 6 wr_reqs → wr_full=1 after the 4th push; 5th and 6th dropped; wr_overflow=1 and stays set; after reads stop, exactly 4 writes drain in FIFO order.
- Simultaneous push/pop at full: full FIFO, rd_req=0, wr_req=1 → pop occurs, push dropped, occupancy becomes 3, wr_overflow=1.
- Reset mid-operation: 2 reads in flight and 3 writes queued, reset pulsed one cycle → no rd_valid, no mem_we afterwards; all outputs at reset values the cycle after reset; the next request behaves as from cold start.
